// File: rtl/sram_controller.sv
// Single-port asynchronous SRAM controller: one byte-wide read or write per request,
// sequenced IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD with a one-cycle response pulse.
module sram_controller #(
    parameter int ADDR_WIDTH  = 17,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  resp_valid,
    output logic [7:0]            resp_rdata,
    output logic                  chip_enable,
    output logic                  chip_enable2,
    output logic                  write_enable,
    output logic                  output_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            data_out,
    output logic                  data_out_en,
    input  logic [7:0]            data_in
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              wait_cnt_reg, wait_cnt_next;
    logic                    write_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              wdata_reg;
    logic [7:0]              rdata_reg;
    logic                    accept;
    logic                    access_last;

    assign accept      = (state_reg == IDLE) && req_valid;
    assign access_last = (state_reg == ACCESS) && (wait_cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = 4'd0;
        case (state_reg)
            IDLE:    if (req_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (wait_cnt_reg == LAST_CNT) begin
                    state_next = HOLD;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured only at the handshake so later input activity is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 8'd0;
            rdata_reg <= 8'd0;
        end else begin
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (access_last && !write_reg) begin
                rdata_reg <= data_in;
            end
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        chip_enable   = 1'b1;
        chip_enable2  = 1'b0;
        write_enable  = 1'b1;
        output_enable = 1'b1;
        data_out_en   = 1'b0;
        case (state_reg)
            IDLE: req_ready = 1'b1;
            SETUP: begin
                chip_enable  = 1'b0;
                chip_enable2 = 1'b1;
                data_out_en  = write_reg;
            end
            ACCESS: begin
                chip_enable   = 1'b0;
                chip_enable2  = 1'b1;
                data_out_en   = write_reg;
                write_enable  = !write_reg;
                output_enable = write_reg;
            end
            HOLD: begin
                chip_enable  = 1'b0;
                chip_enable2 = 1'b1;
                data_out_en  = write_reg;
                resp_valid   = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign address    = addr_reg;
    assign data_out   = wdata_reg;
    assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: two instances (WAIT_CYCLES=1 and 4), an SRAM device
// model on each, and a reference memory that predicts every pin waveform and read result.
module tb_sram_controller;

    localparam int AW = 17;

    logic            clk = 1'b0;
    logic            rst           [2];
    logic            req_valid     [2];
    logic            req_ready     [2];
    logic            req_write     [2];
    logic [AW-1:0]   req_addr      [2];
    logic [7:0]      req_wdata     [2];
    logic            resp_valid    [2];
    logic [7:0]      resp_rdata    [2];
    logic            chip_enable   [2];
    logic            chip_enable2  [2];
    logic            write_enable  [2];
    logic            output_enable [2];
    logic [AW-1:0]   address       [2];
    logic [7:0]      data_out      [2];
    logic            data_out_en   [2];
    logic [7:0]      data_in       [2];

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              hs_cyc   [2];
    logic [7:0]      last_rd  [2];
    bit              chk_on   = 1'b0;
    logic [7:0]      sram_mem [int];
    logic [7:0]      ref_mem  [int];
    logic [AW-1:0]   pool     [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_controller #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .chip_enable(chip_enable[0]), .chip_enable2(chip_enable2[0]),
        .write_enable(write_enable[0]), .output_enable(output_enable[0]),
        .address(address[0]), .data_out(data_out[0]), .data_out_en(data_out_en[0]),
        .data_in(data_in[0])
    );

    sram_controller #(.ADDR_WIDTH(AW), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .chip_enable(chip_enable[1]), .chip_enable2(chip_enable2[1]),
        .write_enable(write_enable[1]), .output_enable(output_enable[1]),
        .address(address[1]), .data_out(data_out[1]), .data_out_en(data_out_en[1]),
        .data_in(data_in[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic int mkey(input int k, input logic [AW-1:0] a);
        return (k << AW) | int'(a);
    endfunction

    // SRAM device model: commits on an active write strobe, drives the bus while output-enabled.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_on && !write_enable[k] && !chip_enable[k] && chip_enable2[k] && data_out_en[k])
                sram_mem[mkey(k, address[k])] = data_out[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!output_enable[k] && !chip_enable[k] && chip_enable2[k])
                data_in[k] = sram_mem.exists(mkey(k, address[k])) ? sram_mem[mkey(k, address[k])]
                                                                   : dflt(address[k]);
            else
                data_in[k] = 8'hEE;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check("we_oe_exclusive", {31'd0, write_enable[k] | output_enable[k]}, 1);
                check("oe_drive_exclusive", {31'd0, output_enable[k] | !data_out_en[k]}, 1);
            end
        end
    end

    // One full transaction; entered and left on a falling edge. With hold set, req_valid stays
    // high with unchanged fields so the next call can hand-shake at the earliest legal edge.
    task automatic run_op(input int k, input bit wr, input logic [AW-1:0] addr,
                          input logic [7:0] wdata, input bit hold);
        int         w;
        bit         got;
        bit         in_op, acc;
        logic [7:0] exp_rd;
        w = (k == 0) ? 1 : 4;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            if (req_ready[k]) got = 1'b1;
            else @(negedge clk);
        end
        check("handshake_timeout", {31'd0, got}, 1);
        if (!got) begin
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc[k] = cyc;
        if (wr) begin
            ref_mem[mkey(k, addr)] = wdata;
            exp_rd = last_rd[k];
        end else begin
            exp_rd = ref_mem.exists(mkey(k, addr)) ? ref_mem[mkey(k, addr)] : dflt(addr);
        end
        if (!hold) begin
            req_valid[k] = 1'($urandom_range(0, 1));
            req_write[k] = 1'($urandom_range(0, 1));
            req_addr[k]  = AW'($urandom);
            req_wdata[k] = 8'($urandom);
        end
        for (int c = 1; c <= w + 3; c++) begin
            @(negedge clk);
            in_op = (c <= w + 2);
            acc   = (c >= 2) && (c <= w + 1);
            check("chip_enable",   {31'd0, chip_enable[k]},   {31'd0, !in_op});
            check("chip_enable2",  {31'd0, chip_enable2[k]},  {31'd0, in_op});
            check("write_enable",  {31'd0, write_enable[k]},  {31'd0, !(wr && acc)});
            check("output_enable", {31'd0, output_enable[k]}, {31'd0, !(!wr && acc)});
            check("data_out_en",   {31'd0, data_out_en[k]},   {31'd0, wr && in_op});
            check("resp_valid",    {31'd0, resp_valid[k]},    {31'd0, c == w + 2});
            check("req_ready",     {31'd0, req_ready[k]},     {31'd0, c == w + 3});
            if (in_op) check("address", 32'(address[k]), 32'(addr));
            if (in_op && wr) check("data_out", 32'(data_out[k]), 32'(wdata));
            if (c == w + 2) check("resp_rdata", 32'(resp_rdata[k]), 32'(exp_rd));
            if (!hold) begin
                req_valid[k] = (c + 1 < w + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_write[k] = 1'($urandom_range(0, 1));
                req_addr[k]  = AW'($urandom);
                req_wdata[k] = 8'($urandom);
            end
        end
        last_rd[k] = exp_rd;
        $display("txn dut%0d %s addr=0x%05h data=0x%02h handshake_cycle=%0d",
                 k, wr ? "WR" : "RD", addr, wr ? wdata : exp_rd, hs_cyc[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1;
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = 8'd0;
            data_in[k]   = 8'hEE;
            last_rd[k]   = 8'd0;
            hs_cyc[k]    = 0;
        end
        for (int i = 0; i < 16; i++) pool[i] = AW'($urandom);
        pool[0] = 17'h1FFFF;
        pool[1] = 17'h00000;
        pool[2] = 17'h1ABCD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_chip_enable",   {31'd0, chip_enable[k]},   1);
            check("rst_chip_enable2",  {31'd0, chip_enable2[k]},  0);
            check("rst_write_enable",  {31'd0, write_enable[k]},  1);
            check("rst_output_enable", {31'd0, output_enable[k]}, 1);
            check("rst_data_out_en",   {31'd0, data_out_en[k]},   0);
            check("rst_address",       32'(address[k]),           0);
            check("rst_data_out",      32'(data_out[k]),          0);
            check("rst_resp_valid",    {31'd0, resp_valid[k]},    0);
            check("rst_resp_rdata",    32'(resp_rdata[k]),        0);
            check("rst_req_ready",     {31'd0, req_ready[k]},     1);
        end
        chk_on = 1'b1;

        // Directed: single write and read-back, then boundary addresses at WAIT_CYCLES=1.
        run_op(0, 1'b1, 17'h1ABCD, 8'h5A, 1'b0);
        run_op(0, 1'b0, 17'h1ABCD, 8'h00, 1'b0);
        run_op(0, 1'b1, 17'h1FFFF, 8'hFF, 1'b0);
        run_op(0, 1'b1, 17'h00000, 8'h00, 1'b0);
        run_op(0, 1'b0, 17'h1FFFF, 8'h00, 1'b0);
        run_op(0, 1'b0, 17'h00000, 8'h00, 1'b0);

        // Back-to-back reads at WAIT_CYCLES=4 with req_valid held high.
        run_op(1, 1'b1, 17'h1ABCD, 8'hC3, 1'b0);
        run_op(1, 1'b0, 17'h1ABCD, 8'h00, 1'b1);
        h1 = hs_cyc[1];
        run_op(1, 1'b0, 17'h1FFFF, 8'h00, 1'b0);
        check("b2b_handshake_gap", 32'(hs_cyc[1] - h1), 7);

        // Reset during the ACCESS phase of a write, with a request pending while reset is high.
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 17'h0F0F0; req_wdata[1] = 8'h99;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("rw_setup_chip_enable", {31'd0, chip_enable[1]}, 0);
        @(negedge clk);
        check("rw_access_write_enable", {31'd0, write_enable[1]}, 0);
        ref_mem[mkey(1, 17'h0F0F0)] = 8'h99;
        rst[1] = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("rw_abort_write_enable",  {31'd0, write_enable[1]},  1);
        check("rw_abort_output_enable", {31'd0, output_enable[1]}, 1);
        check("rw_abort_chip_enable",   {31'd0, chip_enable[1]},   1);
        check("rw_abort_data_out_en",   {31'd0, data_out_en[1]},   0);
        check("rw_abort_resp_valid",    {31'd0, resp_valid[1]},    0);
        @(negedge clk);
        check("rw_no_accept_in_rst",    {31'd0, chip_enable[1]},   1);
        check("rw_rst_address",         32'(address[1]),           0);
        rst[1] = 1'b0;
        req_valid[1] = 1'b0;
        last_rd[1] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_after_req_ready",  {31'd0, req_ready[1]},   1);
            check("rw_after_resp_valid", {31'd0, resp_valid[1]},  0);
            check("rw_after_chip_enable", {31'd0, chip_enable[1]}, 1);
        end

        // Randomized traffic on both instances over a small address pool.
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 2; k++) begin
                run_op(k, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
                       8'($urandom), 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, the SRAM address width in bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, the number of ACCESS-state cycles; the legal range is 1..15.
REQ-003 SHALL use one clock and a synchronous, active-high reset. The ports are:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have the following request/response ports:
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  8  write data.
- resp_valid  output  1  one-cycle completion pulse, for reads and writes.
- resp_rdata  output  8  read data.
REQ-005 SHALL have the following SRAM pin ports:
- chip_enable  output  1  active-low chip select.
- chip_enable2  output  1  active-high chip select.
- write_enable  output  1  active-low write strobe.
- output_enable  output  1  active-low SRAM output enable.
- address  output  ADDR_WIDTH  SRAM address.
- data_out  output  8  data driven toward the SRAM.
- data_out_en  output  1  bus drive enable; 1 = controller drives the bus.
- data_in  input  8  sampled SRAM bus.

Function
REQ-006 SHALL implement a state machine with states IDLE, SETUP, ACCESS and HOLD.
REQ-007 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid and req_ready are both 1 at a rising edge.
REQ-008 On a handshake, SHALL latch req_write, req_addr and req_wdata, and move IDLE->SETUP; without a handshake it SHALL stay in IDLE.
REQ-009 SHALL hold address, data_out and the latched operation type constant from SETUP through HOLD; changes on the req_* inputs after the handshake SHALL have no effect.
REQ-010 SHALL move SETUP->ACCESS after exactly 1 cycle.
REQ-011 SHALL stay in ACCESS for exactly WAIT_CYCLES cycles, counted by an internal 4-bit counter, then move to HOLD.
REQ-012 SHALL move HOLD->IDLE after exactly 1 cycle; back-to-back requests therefore have a minimum spacing of WAIT_CYCLES+3 cycles.
REQ-013 SHALL drive chip_enable=0 and chip_enable2=1 in SETUP, ACCESS and HOLD, and chip_enable=1, chip_enable2=0 in IDLE.
REQ-014 For reads, SHALL drive output_enable=0 in ACCESS only and keep data_out_en=0 in every state.
REQ-015 For reads, SHALL register data_in into resp_rdata at the rising edge that ends the last ACCESS cycle.
REQ-016 For writes, SHALL drive data_out_en=1 in SETUP, ACCESS and HOLD, and write_enable=0 in ACCESS only.
REQ-017 For writes, SHALL keep output_enable=1 in every state.
REQ-018 SHALL never assert write_enable=0 and output_enable=0 in the same cycle.
REQ-019 SHALL never assert output_enable=0 in any cycle in which data_out_en=1.
REQ-020 SHALL assert resp_valid=1 for exactly the single HOLD cycle of every operation.
REQ-021 SHALL define latency relative to the handshake cycle (cycle 0): SETUP is cycle 1, ACCESS is cycles 2..WAIT_CYCLES+1, HOLD/resp_valid is cycle WAIT_CYCLES+2, and req_ready returns at cycle WAIT_CYCLES+3.
REQ-022 For writes, SHALL leave resp_rdata holding its previous value.
REQ-023 SHALL wrap no address; address is exactly req_addr, and all ADDR_WIDTH bits are passed through.
REQ-024 SHALL keep SRAM control pins inactive in IDLE even when req_valid=1 is held without a handshake edge.

Reset
REQ-025 While rst=1 at a rising edge, SHALL set state=IDLE and the ACCESS counter to 0.
REQ-026 Reset SHALL drive the following values:
- SRAM pins: chip_enable=1, chip_enable2=0, write_enable=1, output_enable=1, data_out_en=0, address=0, data_out=0.
- Response outputs: resp_valid=0, resp_rdata=0.
- Handshake: req_ready=1 from the first cycle after reset.
REQ-027 A reset asserted mid-operation SHALL abort it in the next cycle: no resp_valid, and write_enable and output_enable return to 1 immediately.
REQ-028 A handshake SHALL NOT be accepted in any cycle in which rst=1.

Verification
REQ-029 Bench SHALL cover a single write at WAIT_CYCLES=1:
- Stimulus: req_write=1, addr=0x1ABCD, wdata=0x5A.
- Response: write_enable=0 in cycle 2 only; data_out_en=1 in cycles 1-3; resp_valid in cycle 3; req_ready in cycle 4.
REQ-030 Bench SHALL cover a read back from an SRAM model:
- Stimulus: read addr=0x1ABCD, after the write in REQ-029.
- Response: output_enable=0 in cycle 2; resp_rdata=0x5A with resp_valid in cycle 3; data_out_en=0 throughout.
REQ-031 Bench SHALL cover WAIT_CYCLES=4 back-to-back reads:
- Stimulus: req_valid held high for two reads.
- Response: ACCESS lasts 4 cycles; resp_valid at cycle 6; second handshake no earlier than cycle 7.
REQ-032 Bench SHALL cover a boundary-address write then read:
- Stimulus: write addr=0x1FFFF, wdata=0xFF, then write addr=0x00000, wdata=0x00, then read both addresses.
- Response: reads return 0xFF and 0x00; the address bus equals each request exactly.
REQ-033 Bench SHALL cover reset mid-write:
- Stimulus: rst=1 during ACCESS of a write.
- Response: next cycle write_enable=1, chip_enable=1, data_out_en=0, no resp_valid, req_ready=1 after rst falls.
REQ-034 Bench SHALL check continuously, in all scenarios:
- write_enable=0 and output_enable=0 never occur together.
- output_enable=0 and data_out_en=1 never occur together.
- Input changes after a handshake never alter address or data_out.
